// File: rtl/poly_clk_seq.sv
`default_nettype none
// ============================================================================
//  Module   : poly_clk_seq
//  Purpose  : Poly-cell chain clock sequencer. Flushes the poly chain after
//             reset or init, then enables the chain and derives two
//             independent base ticks (64 kHz / 15 kHz) from clk with
//             free-running prescalers that freeze under debug halt.
//
//  Ports
//    clk        in   single clock, all state updates on its rising edge
//    R          in   synchronous active-high reset
//    init       in   hold chain cleared / prescalers stopped while high
//    halt       in   debug freeze of poly stepping and prescalers
//    sel15k     in   base_tick source select (1 = 15 kHz, 0 = 64 kHz)
//    enp, enn   out  poly-chain positive / negative phase enables
//    poly_R     out  clear input to every poly-chain cell
//    tick64     out  one-cycle 64 kHz pulse
//    tick15     out  one-cycle 15 kHz pulse
//    base_tick  out  tick15 if sel15k else tick64
//    busy       out  high while the chain is being flushed
//
//  Revision : 1.0  initial release
// ============================================================================
module poly_clk_seq #(
    parameter int POLY_LEN = 17,
    parameter int DIV64    = 28,
    parameter int DIV15    = 114
) (
    input  logic clk,
    input  logic R,
    input  logic init,
    input  logic halt,
    input  logic sel15k,
    output logic enp,
    output logic enn,
    output logic poly_R,
    output logic tick64,
    output logic tick15,
    output logic base_tick,
    output logic busy
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_W64 = (DIV64 > 1) ? $clog2(DIV64) : 1;
    localparam int c_W15 = (DIV15 > 1) ? $clog2(DIV15) : 1;
    localparam int c_WFL = (POLY_LEN > 0) ? $clog2(POLY_LEN + 1) : 1;

    localparam logic [c_W64-1:0] c_LAST64     = c_W64'(DIV64 - 1);
    localparam logic [c_W15-1:0] c_LAST15     = c_W15'(DIV15 - 1);
    localparam logic [c_W64-1:0] c_ONE64      = c_W64'(1);
    localparam logic [c_W15-1:0] c_ONE15      = c_W15'(1);
    localparam logic [c_WFL-1:0] c_FLUSH_LAST = c_WFL'(POLY_LEN - 1);
    localparam logic [c_WFL-1:0] c_FLUSH_ONE  = c_WFL'(1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state, counters and outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [c_WFL-1:0] r_flushCnt;
    logic [c_W64-1:0] r_pre64;
    logic [c_W15-1:0] r_pre15;
    logic             r_enp;
    logic             r_polyR;
    logic             r_busy;
    logic             r_tick64;
    logic             r_tick15;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_stateNext;
    logic [c_WFL-1:0] w_flushNext;
    logic [c_W64-1:0] w_pre64Next;
    logic [c_W15-1:0] w_pre15Next;
    logic             w_runActive;
    logic             w_enpNext;
    logic             w_polyRNext;
    logic             w_busyNext;
    logic             w_tick64Next;
    logic             w_tick15Next;

    // State transitions. init seen during FLUSH only matters in the last
    // flush cycle (choosing HOLD over RUN); it never restarts the flush.
    always_comb begin
        w_stateNext = r_state;
        w_flushNext = r_flushCnt;
        case (r_state)
            ST_RST: begin
                w_stateNext = ST_FLUSH;
                w_flushNext = '0;
            end
            ST_FLUSH: begin
                if (r_flushCnt == c_FLUSH_LAST) begin
                    w_stateNext = init ? ST_HOLD : ST_RUN;
                    w_flushNext = '0;
                end else begin
                    w_flushNext = r_flushCnt + c_FLUSH_ONE;
                end
            end
            ST_HOLD: begin
                if (!init) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init) begin
                    w_stateNext = ST_FLUSH;
                    w_flushNext = '0;
                end
            end
            default: begin
                w_stateNext = ST_RST;
                w_flushNext = '0;
            end
        endcase
    end

    // Prescalers. They are zero outside RUN and on the first RUN cycle, and
    // advance at the end of each RUN cycle that was not halted. Inside RUN,
    // r_enp is high exactly in non-halted cycles, so it doubles as the
    // "this cycle counted" flag without a separate halt register.
    always_comb begin
        w_pre64Next = '0;
        w_pre15Next = '0;
        if ((r_state == ST_RUN) && (w_stateNext == ST_RUN)) begin
            w_pre64Next = r_pre64;
            w_pre15Next = r_pre15;
            if (r_enp) begin
                w_pre64Next = (r_pre64 == c_LAST64) ? '0 : (r_pre64 + c_ONE64);
                w_pre15Next = (r_pre15 == c_LAST15) ? '0 : (r_pre15 + c_ONE15);
            end
        end
    end

    // Output values for the cycle about to begin. halt sampled at the edge
    // applies to the cycle that edge starts.
    always_comb begin
        w_runActive  = (w_stateNext == ST_RUN) && !halt;
        w_enpNext    = (w_stateNext == ST_FLUSH) || w_runActive;
        w_polyRNext  = (w_stateNext != ST_RUN);
        w_busyNext   = (w_stateNext == ST_RST) || (w_stateNext == ST_FLUSH);
        w_tick64Next = w_runActive && (w_pre64Next == c_LAST64);
        w_tick15Next = w_runActive && (w_pre15Next == c_LAST15);
    end

    // ------------------------------------------------------------------
    // Sequencer register bank; R overrides everything, mid-flush included.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= ST_RST;
            r_flushCnt <= '0;
            r_pre64    <= '0;
            r_pre15    <= '0;
            r_enp      <= 1'b0;
            r_polyR    <= 1'b1;
            r_busy     <= 1'b1;
            r_tick64   <= 1'b0;
            r_tick15   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_flushCnt <= w_flushNext;
            r_pre64    <= w_pre64Next;
            r_pre15    <= w_pre15Next;
            r_enp      <= w_enpNext;
            r_polyR    <= w_polyRNext;
            r_busy     <= w_busyNext;
            r_tick64   <= w_tick64Next;
            r_tick15   <= w_tick15Next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Both phase enables share one flop so they can never differ.
    // base_tick is the only output with a combinational input path.
    // ------------------------------------------------------------------
    assign enp       = r_enp;
    assign enn       = r_enp;
    assign poly_R    = r_polyR;
    assign busy      = r_busy;
    assign tick64    = r_tick64;
    assign tick15    = r_tick15;
    assign base_tick = sel15k ? r_tick15 : r_tick64;

endmodule
`default_nettype wire

// File: tb/tb_poly_clk_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_clk_seq
//  Purpose  : Self-checking bench for poly_clk_seq. A mode-level reference
//             model (mode, flush cycle number, count of non-halted RUN
//             cycles) predicts every output each cycle; directed steps
//             cover reset, init hold, halt freeze, sel15k muxing and
//             flush restarts, followed by a randomized stretch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_clk_seq;

    localparam int POLY_LEN = 17;
    localparam int DIV64    = 28;
    localparam int DIV15    = 114;

    localparam int M_RST   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_HOLD  = 2;
    localparam int M_RUN   = 3;

    logic clk    = 1'b0;
    logic R      = 1'b1;
    logic init   = 1'b0;
    logic halt   = 1'b0;
    logic sel15k = 1'b0;
    logic enp, enn, poly_R, tick64, tick15, base_tick, busy;

    int nCompared = 0;
    int nMismatch = 0;
    int cyc       = 0;

    // Reference model state
    int   mMode     = M_RST;
    int   mFlushCyc = 0;   // 1-based number of the current flush cycle
    int   mRunN     = 0;   // non-halted RUN cycles completed since RUN entry
    bit   mHalted   = 1'b0;
    logic eEnp  = 1'b0;
    logic ePolyR = 1'b1;
    logic eBusy = 1'b1;
    logic eT64  = 1'b0;
    logic eT15  = 1'b0;

    poly_clk_seq #(
        .POLY_LEN (POLY_LEN),
        .DIV64    (DIV64),
        .DIV15    (DIV15)
    ) dut (
        .clk       (clk),
        .R         (R),
        .init      (init),
        .halt      (halt),
        .sel15k    (sel15k),
        .enp       (enp),
        .enn       (enn),
        .poly_R    (poly_R),
        .tick64    (tick64),
        .tick15    (tick15),
        .base_tick (base_tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        nCompared++;
        assert (obs == exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge with the inputs present there.
    task automatic modelEdge(input logic r, input logic i, input logic h);
        if (r) begin
            mMode = M_RST;
        end else begin
            case (mMode)
                M_RST: begin
                    mMode     = M_FLUSH;
                    mFlushCyc = 1;
                end
                M_FLUSH: begin
                    if (mFlushCyc == POLY_LEN) begin
                        mMode = i ? M_HOLD : M_RUN;
                        mRunN = 0;
                    end else begin
                        mFlushCyc++;
                    end
                end
                M_HOLD: begin
                    if (!i) begin
                        mMode = M_RUN;
                        mRunN = 0;
                    end
                end
                default: begin
                    if (i) begin
                        mMode     = M_FLUSH;
                        mFlushCyc = 1;
                    end else if (!mHalted) begin
                        mRunN++;
                    end
                end
            endcase
        end
        mHalted = h;
        eEnp   = (mMode == M_FLUSH) || ((mMode == M_RUN) && !h);
        ePolyR = (mMode != M_RUN);
        eBusy  = (mMode == M_RST) || (mMode == M_FLUSH);
        eT64   = (mMode == M_RUN) && !h && ((mRunN % DIV64) == DIV64 - 1);
        eT15   = (mMode == M_RUN) && !h && ((mRunN % DIV15) == DIV15 - 1);
    endtask

    task automatic checkOutputs();
        chk("enp",       enp,       eEnp);
        chk("enn",       enn,       eEnp);
        chk("poly_R",    poly_R,    ePolyR);
        chk("busy",      busy,      eBusy);
        chk("tick64",    tick64,    eT64);
        chk("tick15",    tick15,    eT15);
        chk("base_tick", base_tick, sel15k ? eT15 : eT64);
        chk("enp_eq_enn", enn, enp);
        chk("polyR_enp_outside_flush", poly_R & enp & ~busy, 1'b0);
    endtask

    // One clock: drive at negedge, check the mux reacts to sel15k in the
    // same cycle, then update the model at posedge and check all outputs.
    task automatic step(input logic r, input logic i, input logic h, input logic s);
        @(negedge clk);
        R      = r;
        init   = i;
        halt   = h;
        sel15k = s;
        #1;
        chk("base_tick_same_cycle", base_tick, s ? eT15 : eT64);
        @(posedge clk);
        cyc++;
        modelEdge(r, i, h);
        #1;
        checkOutputs();
    endtask

    initial begin
        int runIdx;
        int first64;
        int second64;
        int first15;
        int guard;
        int k;
        int cnt;
        bit sawActivity;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);

        // Plain start-up: RST, 17 flush cycles, RUN with tick positions
        runIdx   = 0;
        first64  = -1;
        second64 = -1;
        first15  = -1;
        for (int n = 0; n < 18 + 240; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (mMode == M_RUN) begin
                runIdx++;
                if (tick64) begin
                    if (first64 < 0)       first64  = runIdx;
                    else if (second64 < 0) second64 = runIdx;
                end
                if (tick15 && (first15 < 0)) first15 = runIdx;
            end
        end
        chkInt("first_tick64_run_cycle", first64, DIV64);
        chkInt("tick64_period", second64 - first64, DIV64);
        chkInt("first_tick15_run_cycle", first15, DIV15);

        // init held through reset: flush, HOLD, release into RUN
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 17 + 10; n++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("hold_enp", enp, 1'b0);
        chk("hold_poly_R", poly_R, 1'b1);
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end

        // Halt for 10 cycles starting where prescaler64 = 20
        guard = 0;
        while (!((mMode == M_RUN) && (((mRunN + (mHalted ? 0 : 1)) % DIV64) == 20))
               && (guard < 200)) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chkInt("halt_alignment_found", (guard < 200) ? 1 : 0, 1);
        sawActivity = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (enp || enn || tick64 || tick15) sawActivity = 1'b1;
        end
        chk("halted_quiet", sawActivity, 1'b0);
        k = -1;
        for (int j = 0; j < 40; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (tick64) begin
                k = j;
                break;
            end
        end
        chkInt("tick64_after_halt", k, 7);

        // Reset at flush cycle 9, then a full flush
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 9; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chkInt("at_flush_cycle_9", mFlushCyc, 9);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (!busy) break;
            if (enp) cnt++;
        end
        chkInt("flush_len_after_reset", cnt, POLY_LEN);

        // init pulse in RUN, with init re-raised mid-flush
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        if (busy && enp) cnt++;
        for (int j = 0; j < 40; j++) begin
            step(1'b0, 1'((j == 4) || (j == 5)), 1'($urandom_range(0, 1)), 1'b0);
            if (!busy) break;
            cnt++;
        end
        chkInt("flush_len_after_init", cnt, POLY_LEN);

        // Randomized stretch
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
